// File: rtl/clk_byp_seq.sv
// Clock bypass/gating sequencer: gates the clocks whose bypass select changes,
// switches the bypass muxes, waits for PLL lock, then applies the requested enables.
//
// state    | meaning
// IDLE     | ready for a new request
// WAIT_OFF | affected clocks gated, settling before the mux switch
// WAIT_ON  | mux switched, settling before re-enable
// LOCK_CHK | waiting for PLL lock (or timeout) before applying enables
module clk_byp_seq #(
  parameter int unsigned        NUM_CLK       = 3,
  parameter int unsigned        SETTLE_CYCLES = 4,
  parameter int unsigned        LOCK_TIMEOUT  = 1024,
  parameter logic [NUM_CLK-1:0] RST_BYP       = '1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               locked_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [NUM_CLK-1:0] req_en_i,
  input  logic [NUM_CLK-1:0] req_byp_i,
  output logic [NUM_CLK-1:0] clk_en_o,
  output logic [NUM_CLK-1:0] byp_en_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               lock_err_o
);

  typedef enum logic [1:0] {IDLE, WAIT_OFF, WAIT_ON, LOCK_CHK} state_t;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [15:0]          wcnt_q, wcnt_d;
  logic [NUM_CLK-1:0]   en_q, en_d, byp_q, byp_d;
  logic [NUM_CLK-1:0]   clk_en_d, byp_en_d, chg;
  logic                 done_d, lock_err_d, ready_d, need_lock;
  logic [1:0]           sync_q;
  logic                 locked_s;

  assign locked_s = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q      <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      en_q        <= '0;
      byp_q       <= '0;
      clk_en_o    <= '1;
      byp_en_o    <= RST_BYP;
      done_o      <= 1'b0;
      lock_err_o  <= 1'b0;
      req_ready_o <= 1'b1;
      busy_o      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], locked_i};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      en_q        <= en_d;
      byp_q       <= byp_d;
      clk_en_o    <= clk_en_d;
      byp_en_o    <= byp_en_d;
      done_o      <= done_d;
      lock_err_o  <= lock_err_d;
      req_ready_o <= ready_d;
      busy_o      <= !ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    en_d       = en_q;
    byp_d      = byp_q;
    clk_en_d   = clk_en_o;
    byp_en_d   = byp_en_o;
    done_d     = 1'b0;
    lock_err_d = lock_err_o;
    chg        = req_byp_i ^ byp_en_o;
    need_lock  = |(en_q & ~byp_q);
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          en_d       = req_en_i;
          byp_d      = req_byp_i;
          lock_err_d = 1'b0;
          cnt_d      = '0;
          wcnt_d     = '0;
          if (chg != '0) begin
            clk_en_d = clk_en_o & ~chg;
            state_d  = WAIT_OFF;
          end else begin
            state_d  = LOCK_CHK;
          end
        end
      end
      WAIT_OFF: begin
        if (cnt_q == SETTLE_LAST) begin
          byp_en_d = byp_q;
          cnt_d    = '0;
          state_d  = WAIT_ON;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_ON: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          wcnt_d  = '0;
          state_d = LOCK_CHK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      LOCK_CHK: begin
        if (!need_lock || locked_s) begin
          clk_en_d = en_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (wcnt_q == LOCK_LAST) begin
          // PLL never locked: only bypass-clocked channels are safe to enable
          clk_en_d   = en_q & byp_q;
          lock_err_d = 1'b1;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_clk_byp_seq.sv
// Directed bench for clk_byp_seq: stimulus pushes expected completions into a
// scoreboard queue, a monitor checks them when done_o pulses.
module tb_clk_byp_seq;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       locked_i = 1'b1;
  logic       req_valid_i = 1'b0;
  logic [2:0] req_en_i = '0;
  logic [2:0] req_byp_i = '0;
  logic       req_ready_o, busy_o, done_o, lock_err_o;
  logic [2:0] clk_en_o, byp_en_o;

  typedef struct {
    logic [2:0] clk_en;
    logic [2:0] byp_en;
    logic       lock_err;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   acc;
  logic [2:0] prev_byp, prev_clk;
  logic       prev_valid = 1'b0;

  clk_byp_seq #(.LOCK_TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .locked_i(locked_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_en_i(req_en_i), .req_byp_i(req_byp_i),
    .clk_en_o(clk_en_o), .byp_en_o(byp_en_o),
    .busy_o(busy_o), .done_o(done_o), .lock_err_o(lock_err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // completion monitor
  always @(negedge clk_i) begin
    if (rst_ni && done_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_o=1 expected no completion (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("final_clk_en", int'(clk_en_o), int'(e.clk_en));
        chk("final_byp_en", int'(byp_en_o), int'(e.byp_en));
        chk("final_lock_err", int'(lock_err_o), int'(e.lock_err));
      end
    end
  end

  // a bypass select may only move while its clock is gated
  always @(negedge clk_i) begin
    if (rst_ni && prev_valid) begin
      for (int i = 0; i < 3; i++) begin
        if (byp_en_o[i] !== prev_byp[i]) begin
          chk($sformatf("byp_while_gated_%0d", i), int'(prev_clk[i] | clk_en_o[i]), 0);
        end
      end
    end
    prev_byp   = byp_en_o;
    prev_clk   = clk_en_o;
    prev_valid = rst_ni;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // called right after a negedge with the DUT idle
  task automatic issue(input logic [2:0] en, input logic [2:0] byp,
                       input logic [2:0] x_clk, input logic [2:0] x_byp,
                       input logic x_err, input int lat);
    exp_t e;
    req_en_i = en;
    req_byp_i = byp;
    req_valid_i = 1'b1;
    @(negedge clk_i);
    acc = cyc;
    req_valid_i = 1'b0;
    e.clk_en = x_clk;
    e.byp_en = x_byp;
    e.lock_err = x_err;
    e.done_cyc = acc + lat;
    sb.push_back(e);
  endtask

  task automatic wait_ready(input int max);
    int n;
    n = 0;
    while (!req_ready_o && n < max) begin
      @(negedge clk_i);
      n++;
    end
    chk("ready_within_budget", int'(req_ready_o), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_clk_en", int'(clk_en_o), 7);
    chk("rst_byp_en", int'(byp_en_o), 7);
    chk("rst_ready", int'(req_ready_o), 1);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_lock_err", int'(lock_err_o), 0);
    repeat (2) @(negedge clk_i);

    // full switch to PLL on all channels
    issue(3'b111, 3'b000, 3'b111, 3'b000, 1'b0, 9);
    chk("accept_gate_off", int'(clk_en_o), 0);
    chk("busy_after_accept", int'(busy_o), 1);
    repeat (3) @(negedge clk_i);
    chk("byp_before_switch", int'(byp_en_o), 7);
    @(negedge clk_i);
    chk("byp_after_switch", int'(byp_en_o), 0);
    wait_ready(40);
    @(negedge clk_i);

    // bypass unchanged: enables only
    issue(3'b101, 3'b000, 3'b101, 3'b000, 1'b0, 1);
    chk("nochg_accept_clk_en", int'(clk_en_o), 7);
    wait_ready(40);
    @(negedge clk_i);

    // back to full bypass, then PLL never locks
    issue(3'b111, 3'b111, 3'b111, 3'b111, 1'b0, 9);
    wait_ready(40);
    locked_i = 1'b0;
    repeat (4) @(negedge clk_i);
    issue(3'b111, 3'b001, 3'b001, 3'b001, 1'b1, 24);
    chk("timeout_accept_gate", int'(clk_en_o), 1);
    wait_ready(60);
    repeat (3) @(negedge clk_i);
    chk("lock_err_sticky", int'(lock_err_o), 1);
    locked_i = 1'b1;
    repeat (3) @(negedge clk_i);
    issue(3'b011, 3'b001, 3'b011, 3'b001, 1'b0, 1);
    chk("lock_err_cleared", int'(lock_err_o), 0);
    wait_ready(40);
    locked_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("unlock_after_done_clk_en", int'(clk_en_o), 3);
    chk("unlock_after_done_err", int'(lock_err_o), 0);
    locked_i = 1'b1;
    repeat (3) @(negedge clk_i);

    // requests while busy are dropped
    issue(3'b111, 3'b110, 3'b111, 3'b110, 1'b0, 9);
    @(negedge clk_i);
    chk("busy_ready_low", int'(req_ready_o), 0);
    req_en_i = 3'b001;
    req_byp_i = 3'b000;
    req_valid_i = 1'b1;
    repeat (2) @(negedge clk_i);
    req_valid_i = 1'b0;
    wait_ready(40);
    repeat (2) @(negedge clk_i);

    // reset in the middle of WAIT_ON
    issue(3'b111, 3'b000, 3'b111, 3'b000, 1'b0, 9);
    repeat (5) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("abort_clk_en", int'(clk_en_o), 7);
    chk("abort_byp_en", int'(byp_en_o), 7);
    chk("abort_ready", int'(req_ready_o), 1);
    chk("abort_done", int'(done_o), 0);
    sb.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (12) @(negedge clk_i);

    // normal operation after the abort
    issue(3'b111, 3'b111, 3'b111, 3'b111, 1'b0, 1);
    wait_ready(40);
    repeat (3) @(negedge clk_i);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_byp_seq.md
CLK_BYP_SEQ -- requirements
Module: clk_byp_seq

Interface
REQ-001 SHALL have parameter NUM_CLK, default 3, number of controlled clock channels (bit 0 slow, 1 soc, 2 per).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, gate-off and post-switch settle length in clk_i cycles (range 1..255).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 1024, maximum cycles waiting for PLL lock (range 1..65535).
REQ-004 SHALL have parameter RST_BYP, default all-ones [NUM_CLK], byp_en_o value at reset.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port locked_i, input, 1, PLL lock status (asynchronous to clk_i).
REQ-008 SHALL have port req_valid_i, input, 1, new configuration request.
REQ-009 SHALL have port req_ready_o, output, 1, request accepted when high together with req_valid_i.
REQ-010 SHALL have port req_en_i, input, NUM_CLK, requested per-channel clock enable.
REQ-011 SHALL have port req_byp_i, input, NUM_CLK, requested per-channel bypass select (1 = bypass clock, 0 = PLL).
REQ-012 SHALL have port clk_en_o, output, NUM_CLK, drives the clock-gate enables of the clock generator.
REQ-013 SHALL have port byp_en_o, output, NUM_CLK, drives the bypass-mux selects of the clock generator.
REQ-014 SHALL have port busy_o, output, 1, sequence in progress.
REQ-015 SHALL have port done_o, output, 1, single-cycle pulse on sequence completion.
REQ-016 SHALL have port lock_err_o, output, 1, sticky lock-timeout flag.

Function
REQ-017 All outputs SHALL be registered; locked_i SHALL pass through a 2-flop synchronizer (locked_s) before use.
REQ-018 FSM states SHALL be IDLE, WAIT_OFF, WAIT_ON, LOCK_CHK.
REQ-019 req_ready_o SHALL equal (state == IDLE); busy_o SHALL equal its inverse; requests presented while busy SHALL be ignored, not queued.
REQ-020 On accept, chg = req_byp_i ^ byp_en_o and the request SHALL be latched; later input changes SHALL have no effect.
REQ-021 Accept with chg != 0: on the accept edge clk_en_o[i] SHALL clear for every i with chg[i]; other bits unchanged; next state WAIT_OFF, counter cleared.
REQ-022 WAIT_OFF SHALL last exactly SETTLE_CYCLES cycles, then on the exit edge byp_en_o SHALL load the latched byp and the state SHALL go to WAIT_ON.
REQ-023 WAIT_ON SHALL last exactly SETTLE_CYCLES cycles, then the state SHALL go to LOCK_CHK.
REQ-024 Accept with chg == 0: the state SHALL go directly to LOCK_CHK; clk_en_o unchanged on the accept edge.
REQ-025 need_lock = |(latched_en & ~latched_byp); in LOCK_CHK, if !need_lock or locked_s, clk_en_o SHALL load latched_en, done_o SHALL pulse, and the state SHALL return to IDLE on that edge.
REQ-026 Latency from accept edge to clk_en_o final SHALL be 2*SETTLE_CYCLES+1 cycles (chg != 0) or 1 cycle (chg == 0) when no lock wait occurs.
REQ-027 In LOCK_CHK a 16-bit wait counter SHALL increment each cycle; on reaching LOCK_TIMEOUT, clk_en_o SHALL load latched_en & latched_byp, lock_err_o SHALL set, done_o SHALL pulse, and the state SHALL return to IDLE.
REQ-028 lock_err_o SHALL clear only on the next accepted request.
REQ-029 locked_s falling after completion SHALL NOT alter any output.
REQ-030 byp_en_o[i] SHALL never change in a cycle where clk_en_o[i] is 1.

Reset
REQ-031 On rst_ni low, asynchronously: state IDLE, clk_en_o all-ones, byp_en_o = RST_BYP, busy_o 0, done_o 0, lock_err_o 0, counters and synchronizer 0.
REQ-032 Reset asserted mid-sequence SHALL abort the sequence immediately with no completion pulse.

Verification
REQ-033 Reset release, no request -> clk_en_o=3'b111, byp_en_o=3'b111, req_ready_o=1, done_o=0.
REQ-034 locked_i=1, req byp=3'b000 en=3'b111 -> clk_en_o=000 on accept edge, byp_en_o=000 after 4 cycles, clk_en_o=111 and done_o pulse at accept+9.
REQ-035 Request with byp unchanged, en=3'b101 -> clk_en_o=101 and done_o at accept+1, byp_en_o never toggles.
REQ-036 LOCK_TIMEOUT=16, locked_i=0, req byp=3'b001 en=3'b111 from byp=111 -> lock_err_o=1, clk_en_o=3'b001 after 16 LOCK_CHK cycles; next accepted request clears lock_err_o.
REQ-037 req_valid_i pulsed with different values during WAIT_OFF -> ignored; final outputs match first request only.
REQ-038 rst_ni pulsed low during WAIT_ON -> outputs immediately at reset values, no done_o pulse; assertion of REQ-030 holds throughout all scenarios.
